// File: rtl/ram68k_ctrl_if.sv
// 68k-side strobes plus the work-RAM pin group seen by the bus-cycle controller.
interface ram68k_ctrl_if;
  logic [14:0] m68k_addr;
  logic [15:0] m68k_din;
  logic [15:0] m68k_dout;
  logic        nas;
  logic        nuds;
  logic        nlds;
  logic        m68k_rw;
  logic        ram_sel;
  logic        ndtack;
  logic [14:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_doe;
  logic [15:0] ram_din;
  logic        nceu;
  logic        ncel;
  logic        noe;
  logic        nwe;

  modport master (
    output m68k_addr, m68k_din, nas, nuds, nlds, m68k_rw, ram_sel, ram_din,
    input  m68k_dout, ndtack, ram_addr, ram_dout, ram_doe, nceu, ncel, noe, nwe
  );

  modport slave (
    input  m68k_addr, m68k_din, nas, nuds, nlds, m68k_rw, ram_sel, ram_din,
    output m68k_dout, ndtack, ram_addr, ram_dout, ram_doe, nceu, ncel, noe, nwe
  );
endinterface

// File: rtl/ram68k_ctrl.sv
// Bus-cycle controller: 68k strobes to two byte-wide async SRAMs with wait states and nDTACK.
// All RAM-side outputs are registered; nOE and nWE are driven from disjoint states so never overlap.
module ram68k_ctrl #(
  parameter int READ_WAIT   = 4,
  parameter int WRITE_PULSE = 3
) (
  input  logic         clk,
  input  logic         reset,
  ram68k_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, ACK_WAIT
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       aborted;
  logic       start;

  assign start = !bus.nas && bus.ram_sel && (!bus.nuds || !bus.nlds);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      aborted       <= 1'b0;
      bus.ndtack    <= 1'b1;
      bus.nceu      <= 1'b1;
      bus.ncel      <= 1'b1;
      bus.noe       <= 1'b1;
      bus.nwe       <= 1'b1;
      bus.ram_doe   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_dout  <= '0;
      bus.m68k_dout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.ram_addr <= bus.m68k_addr;
            bus.nceu     <= bus.nuds;
            bus.ncel     <= bus.nlds;
            aborted      <= 1'b0;
            if (bus.m68k_rw) begin
              state   <= RD_WAIT;
              bus.noe <= 1'b0;
              cnt     <= 4'(READ_WAIT - 1);
            end else begin
              state        <= WR_SETUP;
              bus.ram_dout <= bus.m68k_din;
              bus.ram_doe  <= 1'b1;
            end
          end
        end

        RD_WAIT: begin
          if (bus.nas) begin
            bus.noe  <= 1'b1;
            bus.nceu <= 1'b1;
            bus.ncel <= 1'b1;
            state    <= IDLE;
          end else if (cnt == 4'd0) begin
            // Only the lanes whose chip was enabled carry valid data.
            if (!bus.nceu) bus.m68k_dout[15:8] <= bus.ram_din[15:8];
            if (!bus.ncel) bus.m68k_dout[7:0]  <= bus.ram_din[7:0];
            bus.ndtack <= 1'b0;
            state      <= ACK_WAIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_SETUP: begin
          if (bus.nas) begin
            bus.nceu    <= 1'b1;
            bus.ncel    <= 1'b1;
            bus.ram_doe <= 1'b0;
            state       <= IDLE;
          end else begin
            bus.nwe <= 1'b0;
            cnt     <= 4'(WRITE_PULSE - 1);
            state   <= WR_PULSE;
          end
        end

        WR_PULSE: begin
          if (bus.nas) begin
            bus.nwe <= 1'b1;
            aborted <= 1'b1;
            state   <= WR_HOLD;
          end else if (cnt == 4'd0) begin
            bus.nwe    <= 1'b1;
            bus.ndtack <= 1'b0;
            state      <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_HOLD: begin
          // Data and chip enable were held one clock past the nWE rise.
          bus.nceu    <= 1'b1;
          bus.ncel    <= 1'b1;
          bus.ram_doe <= 1'b0;
          state       <= aborted ? IDLE : ACK_WAIT;
        end

        ACK_WAIT: begin
          if (bus.nas) begin
            bus.ndtack <= 1'b1;
            bus.nceu   <= 1'b1;
            bus.ncel   <= 1'b1;
            bus.noe    <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram68k_ctrl.sv
// Randomised scoreboard bench for ram68k_ctrl with a behavioural SRAM pair and word-level reference model.
module tb_ram68k_ctrl;
  localparam int READ_WAIT   = 4;
  localparam int WRITE_PULSE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram68k_ctrl_if bus();

  ram68k_ctrl #(.READ_WAIT(READ_WAIT), .WRITE_PULSE(WRITE_PULSE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical SRAM contents and the reference model's view of them.
  logic [7:0]  mem_hi [0:32767];
  logic [7:0]  mem_lo [0:32767];
  logic [7:0]  ref_hi [0:32767];
  logic [7:0]  ref_lo [0:32767];
  logic [15:0] exp_dout = 16'h0000;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    int          start;
  } exp_t;
  exp_t sb[$];

  assign bus.ram_din = {(!bus.nceu && !bus.noe) ? mem_hi[bus.ram_addr] : 8'hEE,
                        (!bus.ncel && !bus.noe) ? mem_lo[bus.ram_addr] : 8'hEE};

  always @(negedge clk) begin
    if (!bus.nwe) begin
      if (!bus.nceu) mem_hi[bus.ram_addr] <= bus.ram_doe ? bus.ram_dout[15:8] : 8'hDE;
      if (!bus.ncel) mem_lo[bus.ram_addr] <= bus.ram_doe ? bus.ram_dout[7:0]  : 8'hAD;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every nDTACK fall and watches bus-level invariants.
  int   viol = 0;
  int   wlen = 0;
  logic prev_ndtack = 1'b1;
  logic prev_nwe = 1'b1;
  logic prev_nce_low = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [15:0] prev_rdout = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (!bus.noe && !bus.nwe) viol++;
      if (!bus.nwe && !bus.ram_doe) viol++;
      if (!bus.nwe && bus.nceu && bus.ncel) viol++;
      if (!bus.nwe && prev_nwe && (!prev_nce_low || bus.ram_addr !== prev_addr)) viol++;
      if (prev_nce_low && (!bus.nceu || !bus.ncel) &&
          (bus.ram_addr !== prev_addr || bus.ram_dout !== prev_rdout)) viol++;
      if (!bus.nwe) wlen++;
      else if (!prev_nwe) begin
        if (!bus.ndtack) check("nwe_width", 32'(wlen), 32'(WRITE_PULSE));
        wlen = 0;
      end
      if (!bus.ndtack && prev_ndtack) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ndtack=0 expected 1 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_latency", 32'(cyc - e.start),
                e.rd ? 32'(1 + READ_WAIT) : 32'(2 + WRITE_PULSE));
          if (e.rd) check("read_data", {16'h0, bus.m68k_dout}, {16'h0, e.data});
        end
      end
    end else begin
      wlen = 0;
    end
    prev_ndtack  = bus.ndtack;
    prev_nwe     = bus.nwe;
    prev_nce_low = !bus.nceu || !bus.ncel;
    prev_addr    = bus.ram_addr;
    prev_rdout   = bus.ram_dout;
  end

  function automatic logic [31:0] ctl();
    return {26'h0, bus.ndtack, bus.nceu, bus.ncel, bus.noe, bus.nwe, bus.ram_doe};
  endfunction

  // Caller is positioned #1 after a rising edge; returns #1 after the release edge.
  task automatic bus_cycle(input logic [14:0] a, input logic [15:0] d, input logic rw,
                           input logic un, input logic ln, input int hold);
    exp_t e;
    int   n;
    logic [31:0] want;
    bus.m68k_addr = a;
    bus.m68k_din  = d;
    bus.m68k_rw   = rw;
    bus.nuds      = un;
    bus.nlds      = ln;
    bus.ram_sel   = 1'b1;
    bus.nas       = 1'b0;
    if (rw) begin
      if (!un) exp_dout[15:8] = ref_hi[a];
      if (!ln) exp_dout[7:0]  = ref_lo[a];
    end else begin
      if (!un) ref_hi[a] = d[15:8];
      if (!ln) ref_lo[a] = d[7:0];
    end
    e.rd = rw;
    e.data = exp_dout;
    e.start = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    want = rw ? {26'h0, 1'b1, un, ln, 1'b0, 1'b1, 1'b0} : {26'h0, 1'b1, un, ln, 1'b1, 1'b1, 1'b1};
    check("edge0_ctrl", ctl(), want);
    check("edge0_addr", 32'(bus.ram_addr), 32'(a));
    n = 0;
    while (bus.ndtack && n < 64) begin @(posedge clk); #1; n++; end
    if (bus.ndtack) check("ack_timeout", 32'(bus.ndtack), 32'h0);
    repeat (hold) begin @(posedge clk); #1; end
    bus.nas  = 1'b1;
    bus.nuds = 1'b1;
    bus.nlds = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.ndtack && n < 8);
    check("release", ctl(), 32'h3E);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] s;
    for (int i = 0; i < 32768; i++) begin
      mem_hi[i] <= 8'(i * 7 + 3);
      mem_lo[i] <= 8'(i ^ 32'h55);
      ref_hi[i] = 8'(i * 7 + 3);
      ref_lo[i] = 8'(i ^ 32'h55);
    end
    mem_hi[15'h0100] <= 8'h12;
    mem_lo[15'h0100] <= 8'h34;
    ref_hi[15'h0100] = 8'h12;
    ref_lo[15'h0100] = 8'h34;

    bus.nas = 1'b1; bus.nuds = 1'b1; bus.nlds = 1'b1; bus.m68k_rw = 1'b1;
    bus.ram_sel = 1'b1; bus.m68k_addr = '0; bus.m68k_din = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ctrl", ctl(), 32'h3E);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
    check("rst_m68k_dout", 32'(bus.m68k_dout), 32'h0);

    // Word read of 0x1234 at 0x0100.
    bus_cycle(15'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 1);

    // Read aborted: nAS rises after edge 2, strobes drop at edge 3.
    bus.m68k_addr = 15'h0200; bus.m68k_rw = 1'b1; bus.nuds = 1'b0; bus.nlds = 1'b0; bus.nas = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_noe_held", 32'(bus.noe), 32'h0);
    bus.nas = 1'b1; bus.nuds = 1'b1; bus.nlds = 1'b1;
    @(posedge clk); #1;
    check("abort_release", ctl(), 32'h3E);
    check("abort_dout_kept", 32'(bus.m68k_dout), 32'h1234);

    // Low-byte write then word read-back at 0x7FFF.
    bus_cycle(15'h7FFF, 16'hABCD, 1'b0, 1'b1, 1'b0, 0);
    bus_cycle(15'h7FFF, 16'h0, 1'b1, 1'b0, 1'b0, 0);

    // Reset landing in the middle of the nWE pulse.
    bus.m68k_addr = 15'h0040; bus.m68k_din = 16'h1357; bus.m68k_rw = 1'b0;
    bus.nuds = 1'b0; bus.nlds = 1'b0; bus.nas = 1'b0;
    n = 0;
    while (bus.nwe && n < 16) begin @(posedge clk); #1; n++; end
    check("pulse_before_reset", 32'(bus.nwe), 32'h0);
    ref_hi[15'h0040] = 8'h13;
    ref_lo[15'h0040] = 8'h57;
    exp_dout = 16'h0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", ctl(), 32'h3E);
    check("midrst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("midrst_m68k_dout", 32'(bus.m68k_dout), 32'h0);
    reset = 1'b0;
    bus.nas = 1'b1; bus.nuds = 1'b1; bus.nlds = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_quiet", ctl(), 32'h3E);

    // Back-to-back write then read at address 5.
    bus_cycle(15'd5, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0);
    bus_cycle(15'd5, 16'h0, 1'b1, 1'b0, 1'b0, 0);

    // Not selected: nothing may move.
    bus.m68k_addr = 15'd5; bus.m68k_rw = 1'b1; bus.ram_sel = 1'b0;
    bus.nuds = 1'b0; bus.nlds = 1'b0; bus.nas = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("unsel_ctrl", ctl(), 32'h3E);
    bus.nas = 1'b1; bus.nuds = 1'b1; bus.nlds = 1'b1; bus.ram_sel = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      s = 2'($urandom_range(1, 3));
      bus_cycle(15'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)),
                !s[1], !s[0], int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    check("protocol_violations", 32'(viol), 32'h0);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram68k_ctrl.md
Name: ram68k_ctrl

Overview:
- Synchronous bus-cycle controller between the 68k bus and the two 32K×8 work-RAM chips (high byte / low byte, 120 ns async SRAM).
- Converts 68k strobes (nAS, nUDS, nLDS, RW) into per-chip nCE, shared nOE/nWE, a registered RAM address, and a write-data drive enable.
- Counts wait states, latches read data, and generates nDTACK.
- Guarantees nOE and nWE are never low together.

Parameters:
READ_WAIT, 4, clocks nOE/nCE are held low before read data is latched; legal range 1..15.
WRITE_PULSE, 3, clocks nWE is held low; legal range 1..15.

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
M68K_ADDR  in  15  68k A15..A1, word address into work RAM
M68K_DIN  in  16  68k write data
M68K_DOUT  out  16  latched read data to 68k
nAS  in  1  68k address strobe, active low, synchronous to CLK
nUDS  in  1  upper data strobe, active low
nLDS  in  1  lower data strobe, active low
M68K_RW  in  1  1 = read, 0 = write
RAM_SEL  in  1  address decode hit for work RAM
nDTACK  out  1  data acknowledge, active low
RAM_ADDR  out  15  address to both chips
RAM_DOUT  out  16  write data; [15:8] to high chip, [7:0] to low chip
RAM_DOE  out  1  1 = top level drives RAM_DOUT onto the RAM data pins
RAM_DIN  in  16  data read from the RAM pins
nCEU  out  1  high-chip enable, active low
nCEL  out  1  low-chip enable, active low
nOE  out  1  shared output enable, active low
nWE  out  1  shared write enable, active low

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values, applied on the edge after RESET is sampled high, including mid-cycle:
  - nDTACK, nCEU, nCEL, nOE, nWE = 1; RAM_DOE = 0.
  - RAM_ADDR = 0, RAM_DOUT = 0, M68K_DOUT = 0.
  - State = IDLE, wait counter = 0.
- Start condition, sampled in IDLE: nAS=0 && RAM_SEL=1 && (nUDS=0 || nLDS=0).
  - Writes start only once a data strobe is low. nAS low with both data strobes high keeps the block in IDLE.
- At the start edge (edge 0): register RAM_ADDR <= M68K_ADDR. Chip-enable selection is registered too: nCEU <= nUDS, nCEL <= nLDS.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, ACK_WAIT.
- Read (M68K_RW=1):
  - Edge 0: go to RD_WAIT; nOE <= 0; selected nCE <= 0; counter <= READ_WAIT-1.
  - Counter decrements each edge.
  - Edge READ_WAIT (counter at 0):
    - Latch strobed byte lanes of RAM_DIN into M68K_DOUT; unstrobed lanes keep their previous value.
    - nDTACK <= 0; go to ACK_WAIT.
    - nOE and nCE stay low in ACK_WAIT.
- Write (M68K_RW=0):
  - Edge 0: go to WR_SETUP; RAM_DOUT <= M68K_DIN; RAM_DOE <= 1; selected nCE <= 0; nWE stays 1.
  - Edge 1: go to WR_PULSE; nWE <= 0; counter <= WRITE_PULSE-1.
  - Edge 1+WRITE_PULSE: nWE <= 1; nDTACK <= 0; go to WR_HOLD. nCE, RAM_DOE and RAM_DOUT are unchanged (data hold).
  - Next edge: nCE <= 1; RAM_DOE <= 0; go to ACK_WAIT.
- ACK_WAIT:
  - While nAS=0, nDTACK stays 0.
  - On the first edge with nAS=1: nDTACK, nCEU, nCEL, nOE <= 1; go to IDLE.
  - A new start may be accepted from IDLE on the following edge.
- Abort (nAS=1 before nDTACK is asserted):
  - In RD_WAIT: release all strobes; go to IDLE; M68K_DOUT unchanged; no nDTACK.
  - In WR_SETUP: release nCE and RAM_DOE; go to IDLE; no write occurs.
  - In WR_PULSE: nWE <= 1; then take a WR_HOLD cycle with nDTACK held at 1; then go to IDLE.
- Invariants:
  - nOE=0 and nWE=0 never hold at the same time.
  - nWE falls only when nCE is already low and RAM_ADDR is stable (at least 1 clock of setup).
  - RAM_ADDR and RAM_DOUT do not change while any nCE is low.
  - nDTACK is never low in IDLE.
- Strobe/address changes while the block is busy are ignored, except the nAS abort rules above.

Test Plan:
- Word read, READ_WAIT=4, RAM holds 0x12 (high) / 0x34 (low) at address 0x0100, both data strobes low → nOE, nCEU, nCEL low from edge 0; nDTACK low after edge 4; M68K_DOUT=0x1234; all strobes released one edge after nAS rises.
- Byte write, nUDS=1, nLDS=0, M68K_DIN=0xABCD, address 0x7FFF → only nCEL goes low; nWE low for exactly 3 clocks, with 1 clock setup and 1 clock hold; RAM_DOE=1 throughout; read-back of the low chip at 0x7FFF=0xCD; high chip unchanged.
- Abort read: nAS rises at edge 2 of a read → strobes released at edge 3; nDTACK never asserted; M68K_DOUT retains its prior value 0x1234.
- RESET asserted during WR_PULSE → next edge nWE=1, nCE*=1, RAM_DOE=0, nDTACK=1, state IDLE; no further RAM activity until a new start.
- Back-to-back cycles write 0x5A5A at address 5, then read address 5 → the read starts the edge after the ACK_WAIT release, returns 0x5A5A, and the bench assertion that nOE and nWE are never both low never fires.
- Non-selected cycle: nAS=0, RAM_SEL=0 → all outputs stay at idle values; nDTACK stays 1.
